// File: rtl/test_outcome_monitor_if.sv
// Snoop bus between a CPU under test and its outcome monitor.
// master = CPU/testbench side, slave = monitor side.
interface test_outcome_monitor_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 11
);
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            retire;
  logic            halt;
  logic            done;
  logic            pass;
  logic [2:0]      fail_code;
  logic [XLEN-1:0] fail_test_id;
  logic            new_test;
  logic [CNTW-1:0] retire_count;

  modport master (
    output rf_we, rf_waddr, rf_wdata, retire, halt,
    input  done, pass, fail_code, fail_test_id,
    input  new_test, retire_count
  );

  modport slave (
    input  rf_we, rf_waddr, rf_wdata, retire, halt,
    output done, pass, fail_code, fail_test_id,
    output new_test, retire_count
  );
endinterface

// File: rtl/test_outcome_monitor.sv
// Watches register-file writes of a self-checking test program
// and reaches a sticky PASS/FAIL verdict with a failure code.
module test_outcome_monitor #(
  parameter int XLEN       = 32,
  parameter int TESTID_REG = 1,
  parameter int FLAG_REG   = 31,
  parameter int NUM_PAIRS  = 1,
  parameter int MAX_RETIRE = 1024,
  localparam int CNTW = $clog2(MAX_RETIRE + 1)
) (
  input logic                 clk,
  input logic                 reset,
  test_outcome_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [2:0] FC_NONE = 3'd0;
  localparam logic [2:0] FC_TAKE = 3'd1;
  localparam logic [2:0] FC_MISM = 3'd2;
  localparam logic [2:0] FC_UNF  = 3'd3;
  localparam logic [2:0] FC_TMO  = 3'd4;

  state_t          r_state;
  logic [XLEN-1:0] r_tid;
  logic [XLEN-1:0] r_flag;
  logic [XLEN-1:0] r_act [NUM_PAIRS];
  logic [XLEN-1:0] r_exp [NUM_PAIRS];
  logic [CNTW-1:0] r_cnt;
  logic            r_done;
  logic            r_pass;
  logic [2:0]      r_code;
  logic [XLEN-1:0] r_ftid;
  logic            r_new;

  state_t          w_next;
  logic [2:0]      w_code;
  logic            w_run;
  logic            w_wr;
  logic            w_wr_tid;
  logic            w_wr_flag;
  logic            w_flag_nz;
  logic            w_take;
  logic            w_mism;
  logic            w_unf;
  logic            w_tmo;

  assign w_run     = (r_state == S_RUN);
  assign w_wr      = mon.rf_we && (mon.rf_waddr != 5'd0);
  assign w_wr_tid  = w_wr && (mon.rf_waddr == 5'(TESTID_REG));
  assign w_wr_flag = w_wr && (mon.rf_waddr == 5'(FLAG_REG));
  assign w_flag_nz = (r_flag != '0);
  assign w_take    = w_flag_nz && (r_flag != r_tid);
  assign w_unf     = mon.halt && !w_flag_nz && (r_tid != '0);
  assign w_tmo     = (r_cnt == CNTW'(MAX_RETIRE));

  always_comb begin
    w_mism = 1'b0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (r_act[k] != r_exp[k]) w_mism = 1'b1;
    end
  end

  // Verdict priority: takeover, mismatch, unfinished, timeout, pass.
  always_comb begin
    w_next = r_state;
    w_code = FC_NONE;
    if (w_run) begin
      if (w_take) begin
        w_next = S_FAIL;
        w_code = FC_TAKE;
      end else if (w_flag_nz && w_mism) begin
        w_next = S_FAIL;
        w_code = FC_MISM;
      end else if (w_unf) begin
        w_next = S_FAIL;
        w_code = FC_UNF;
      end else if (w_tmo) begin
        w_next = S_FAIL;
        w_code = FC_TMO;
      end else if (mon.halt) begin
        w_next = S_PASS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_tid   <= '0;
      r_flag  <= '0;
      for (int k = 0; k < NUM_PAIRS; k++) begin
        r_act[k] <= '0;
        r_exp[k] <= '0;
      end
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_code <= FC_NONE;
      r_ftid <= '0;
      r_new  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_new   <= 1'b0;
      if (w_run) begin
        if (w_wr_tid)  r_tid  <= mon.rf_wdata;
        if (w_wr_flag) r_flag <= mon.rf_wdata;
        for (int k = 0; k < NUM_PAIRS; k++) begin
          if (w_wr && mon.rf_waddr == 5'(29 - 2 * k))
            r_act[k] <= mon.rf_wdata;
          if (w_wr && mon.rf_waddr == 5'(30 - 2 * k))
            r_exp[k] <= mon.rf_wdata;
        end
        if (mon.retire && !w_tmo) r_cnt <= r_cnt + CNTW'(1);
        r_new <= w_wr_tid && (mon.rf_wdata != r_tid) &&
                 (w_next == S_RUN);
        if (w_next != S_RUN) begin
          r_done <= 1'b1;
          r_pass <= (w_next == S_PASS);
          r_code <= w_code;
          if (w_next == S_FAIL) r_ftid <= r_tid;
        end
      end
    end
  end

  assign mon.done         = r_done;
  assign mon.pass         = r_pass;
  assign mon.fail_code    = r_code;
  assign mon.fail_test_id = r_ftid;
  assign mon.new_test     = r_new;
  assign mon.retire_count = r_cnt;

endmodule

// File: doc/test_outcome_monitor.md
TEST_OUTCOME_MONITOR -- requirements
Module: test_outcome_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter TESTID_REG, default 1, meaning the register index holding the current test number.
REQ-003 SHALL have parameter FLAG_REG, default 31, meaning the register index of the pass/check flag.
REQ-004 SHALL have parameter NUM_PAIRS, default 1 (legal 1..4), meaning the number of compare pairs; pair k has actual = x(29-2k) and expected = x(30-2k).
REQ-005 SHALL have parameter MAX_RETIRE, default 1024, meaning the retirement budget before timeout; CNTW = $clog2(MAX_RETIRE+1).
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1, meaning a synchronous, active-low reset (0 = reset).
REQ-008 SHALL have port rf_we, input, 1, meaning the CPU register-file write enable (snooped).
REQ-009 SHALL have port rf_waddr, input, 5, meaning the register-file write index.
REQ-010 SHALL have port rf_wdata, input, XLEN, meaning the register-file write data.
REQ-011 SHALL have port retire, input, 1, meaning one instruction retired this cycle.
REQ-012 SHALL have port halt, input, 1, meaning an illegal/undefined instruction was fetched or program memory ended.
REQ-013 SHALL have port done, output, 1, meaning a verdict has been reached (sticky).
REQ-014 SHALL have port pass, output, 1, meaning the verdict is PASS (valid when done=1).
REQ-015 SHALL have port fail_code, output, 3, meaning: 0 none, 1 TAKEOVER, 2 MISMATCH, 3 UNFINISHED, 4 TIMEOUT.
REQ-016 SHALL have port fail_test_id, output, XLEN, meaning the test-id shadow captured at failure.
REQ-017 SHALL have port new_test, output, 1, meaning a one-cycle pulse when the test id changes value.
REQ-018 SHALL have port retire_count, output, CNTW, meaning retirements since reset, saturating at MAX_RETIRE.

Function
REQ-019 SHALL keep shadow registers test_id, flag, act[k], exp[k], each updated at the edge where rf_we=1 and rf_waddr matches its index; writes with rf_waddr=0 SHALL be ignored.
REQ-020 SHALL implement FSM states RUN, PASS, FAIL; PASS and FAIL are absorbing until reset.
REQ-021 In RUN, each cycle with registered flag!=0 SHALL evaluate: flag!=test_id -> TAKEOVER; else any act[k]!=exp[k] -> MISMATCH; the result is committed at the next edge.
REQ-022 Latency: a flag write at edge N SHALL yield done=1 after edge N+1, never at N.
REQ-023 halt=1 in RUN SHALL commit at the same edge: UNFINISHED if flag==0 and test_id!=0; otherwise PASS.
REQ-024 SHALL increment retire_count on retire=1 in RUN; when it reaches MAX_RETIRE, SHALL commit TIMEOUT at the next edge.
REQ-025 Simultaneous conditions SHALL be prioritised TAKEOVER > MISMATCH > UNFINISHED > TIMEOUT > PASS.
REQ-026 SHALL capture fail_test_id from the test_id shadow at the edge entering FAIL and hold it thereafter.
REQ-027 new_test SHALL pulse for exactly one cycle after an edge where test_id changed value; rewriting the same value SHALL produce no pulse; the pulse SHALL be suppressed outside RUN.
REQ-028 In PASS/FAIL, shadows and retire_count SHALL freeze and further inputs SHALL be ignored.
REQ-029 Outputs SHALL be registered; comparisons SHALL be full XLEN width and unsigned equality only.

Reset
REQ-030 While reset=0 at an edge: state=RUN, all shadows=0, retire_count=0, done=0, pass=0, fail_code=0, fail_test_id=0, new_test=0.
REQ-031 Reset asserted mid-run or after a verdict SHALL discard all state at that edge; rf/retire/halt inputs in that cycle SHALL be ignored.

Verification
REQ-032 Write x1=3, x29=x30=0x55, x31=3, halt two cycles later -> done=1, pass=1, fail_code=0.
REQ-033 x1=4, x29=0x10, x30=0x11, x31=4 -> done=1 two edges after the x31 write, fail_code=2, fail_test_id=4.
REQ-034 x1=5, x31=6 -> fail_code=1, fail_test_id=5; x1=5 written twice -> exactly one new_test pulse.
REQ-035 x1=7, x31 never set, halt=1 -> fail_code=3; same with x1=0 -> pass=1.
REQ-036 MAX_RETIRE=8, retire held high, no halt -> retire_count=8, fail_code=4; reset=0 for one edge -> all outputs 0.
REQ-037 NUM_PAIRS=2, pair 1 (x27 vs x28) mismatched with pair 0 equal, same-cycle halt -> fail_code=2 (priority over halt).
